uc_sweep_ctrl: RTL and testbench
================================

# uc_sweep_ctrl

Frequency-sweep sequencer for the uberClock RX path. It steps the down-conversion phase increment through a CPU-programmed list of equally spaced points. At each point it waits a settle interval, then integrates the decimated I/Q samples (`downsampled_x/y`, qualified by `ce_down`) over a dwell window. Each per-point sum is handed to the CPU/LiteX CSR layer through a valid/ready handshake, turning the datapath into a swept network analyser without CPU timing involvement.

## Interface
- `PW`, 19, phase-increment width (matches NCO/rx_channel)
- `DW`, 16, signed I/Q sample width
- `CW`, 16, settle/dwell/point counter width
- `AW`, `DW+CW`, signed accumulator width (no overflow possible)

- `sys_clk` in 1, system clock
- `rst` in 1, asynchronous, active-high reset
- `start` in 1, single-cycle pulse; begins a sweep from IDLE/DONE
- `abort` in 1, single-cycle pulse; terminates sweep
- `cfg_start_inc` in PW, phase increment of point 0
- `cfg_step_inc` in PW, increment added per point (modulo 2^PW)
- `cfg_n_points` in CW, number of points
- `cfg_settle` in CW, ce_down ticks discarded per point
- `cfg_dwell` in CW, ce_down ticks integrated per point (0 treated as 1)
- `ce_down` in 1, decimated-sample strobe
- `sample_x`, `sample_y` in DW signed, decimated I/Q
- `phase_inc_down` out PW, drives rx_channel down-conversion increment
- `res_valid` out 1, result available
- `res_ready` in 1, CPU consumes result
- `res_x_sum`, `res_y_sum` out AW signed, integrated I/Q
- `res_index` out CW, point index of the result
- `busy` out 1, high in SETTLE/DWELL/STORE
- `done` out 1, high in DONE

## Operation
- States: IDLE, SETTLE, DWELL, STORE, DONE.
- IDLE/DONE + `start`: latch all `cfg_*`; `index`←0; `phase_inc_down`←`cfg_start_inc`; clear counters; → SETTLE. If `cfg_n_points`=0 → DONE directly, with `phase_inc_down` unchanged.
- SETTLE: count `ce_down` ticks. When the count reaches `cfg_settle` → DWELL. A `cfg_settle` of 0 → DWELL the cycle after entry.
- DWELL: on each `ce_down`, sum `sample_x/y` (sign-extended to AW). After `max(cfg_dwell,1)` samples → STORE, copying sums to `res_*_sum` and `index` to `res_index`, and asserting `res_valid`.
- STORE: hold until `res_valid && res_ready`. On the transfer: deassert `res_valid`.
  - If `index`=`n_points−1` → DONE.
  - Else `index`+1, `phase_inc_down`+=`step` (wraps mod 2^PW), clear sums and counters, → SETTLE.
- No sample is lost or double-counted across a stall: DWELL ignores `ce_down` once complete, and STORE ignores `ce_down`.
- `abort` (any state, priority over `start`/handshake) → IDLE next cycle.
  - `res_valid`←0, sums cleared.
  - `phase_inc_down` holds its last value.
- `start` while `busy` is ignored. `cfg_*` changes during a sweep have no effect.
- DONE: `done`=1 until `start` or `abort`. `start` from DONE restarts.

## Timing
- Reset: state IDLE; `phase_inc_down`=0, `res_valid`=0, `res_*_sum`=0, `res_index`=0, `busy`=0, `done`=0.
- All outputs are registered.
- `phase_inc_down` changes the cycle after `start` or after the STORE handshake. The settle window absorbs CORDIC/CIC latency.
- A `ce_down` on the cycle of entry into SETTLE/DWELL counts.
- Result appears one cycle after the last dwell sample, in the same cycle as `res_valid` rising.
- `res_ready` held high gives zero stall: STORE lasts one cycle.
- Sweep length with no stall = n_points × (settle+dwell) ce_down periods + ≤3 cycles per point.

## Structure
- `uc_ctrl_pkg`: state enum, default widths, and helper `AW` = DW+CW.
- Sub-module `uc_iq_accum`: clear/enable signed dual accumulator with a sample counter, reused by future capture blocks.
- FSM, phase stepping, and handshake live in the top module.

## Test plan
- Reset mid-DWELL → all outputs at reset values immediately; IDLE after release.
- Sweep test:
  - Stimulus: start=1000, step=500, n=3, settle=2, dwell=4, constant x=100, y=−50, ready=1.
  - Expected: `phase_inc_down` 1000/1500/2000, results (400,−200) with indices 0,1,2, then `done`.
- Back-pressure: `res_ready`=0 for 20 cycles with `ce_down` toggling → `res_valid` stays high, sums unchanged, no advance; next point's sums are exact after release.
- Wrap and dwell=0: start=2^19−100, step=300, dwell=0 → second increment 200; each result = one sample.
- Abort in SETTLE of point 1 → IDLE next cycle, `res_valid`=0, `phase_inc_down` stays at point-1 value. A subsequent `start` restarts at index 0.
- Overflow bound: dwell=65535, x=−32768 → `res_x_sum`=−2147450880, exact, no wrap.

Source files
------------

// File: rtl/uc_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uc_ctrl_pkg
// Description : Shared types and default widths for the uberClock sweep
//               controller and its I/Q accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
package uc_ctrl_pkg;

  // Default widths: phase increment (NCO), I/Q sample, counters
  localparam int c_pw_default = 19;
  localparam int c_dw_default = 16;
  localparam int c_cw_default = 16;

  // Accumulator width large enough that CW-bit counts of DW-bit samples never wrap
  function automatic int acc_width(input int dw, input int cw);
    return dw + cw;
  endfunction

  // Sweep sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_DWELL  = 3'd2,
    ST_STORE  = 3'd3,
    ST_DONE   = 3'd4
  } sweep_state_t;

endpackage
`default_nettype wire

// File: rtl/uc_sweep_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : uc_sweep_ctrl_if
// Description : Per-point result channel (valid/ready) from the sweep
//               sequencer to the CPU/CSR layer.
// Revision    : 1.0 - initial release
// ============================================================================
interface uc_sweep_ctrl_if
  import uc_ctrl_pkg::*;
#(
  parameter int AW = acc_width(c_dw_default, c_cw_default),
  parameter int CW = c_cw_default
) ();

  logic                 res_valid;
  logic                 res_ready;
  logic signed [AW-1:0] res_x_sum;
  logic signed [AW-1:0] res_y_sum;
  logic [CW-1:0]        res_index;

  // Producer side: the sweep sequencer
  modport master (
    output res_valid,
    output res_x_sum,
    output res_y_sum,
    output res_index,
    input  res_ready
  );

  // Consumer side: CSR bridge / CPU
  modport slave (
    input  res_valid,
    input  res_x_sum,
    input  res_y_sum,
    input  res_index,
    output res_ready
  );

endinterface
`default_nettype wire

// File: rtl/uc_iq_accum.sv
`default_nettype none
// ============================================================================
// Module      : uc_iq_accum
// Description : Signed dual (I/Q) accumulator with synchronous clear,
//               enable and a sample counter. Exposes the look-ahead sums
//               (current total plus the present sample) so a consumer can
//               capture the final total on the same edge as the last add.
// Revision    : 1.0 - initial release
// ============================================================================
module uc_iq_accum
  import uc_ctrl_pkg::*;
#(
  parameter int DW = c_dw_default,
  parameter int CW = c_cw_default,
  parameter int AW = acc_width(DW, CW)
) (
  input  wire logic                 sys_clk,
  input  wire logic                 rst,
  input  wire logic                 clear,
  input  wire logic                 en,
  input  wire logic signed [DW-1:0] sample_x,
  input  wire logic signed [DW-1:0] sample_y,
  output logic signed [AW-1:0]      x_sum_next,
  output logic signed [AW-1:0]      y_sum_next,
  output logic [CW-1:0]             count
);

  logic signed [AW-1:0] r_x_sum;
  logic signed [AW-1:0] r_y_sum;
  logic [CW-1:0]        r_count;
  logic signed [AW-1:0] w_x_ext;
  logic signed [AW-1:0] w_y_ext;

  assign w_x_ext    = {{(AW-DW){sample_x[DW-1]}}, sample_x};
  assign w_y_ext    = {{(AW-DW){sample_y[DW-1]}}, sample_y};
  assign x_sum_next = r_x_sum + w_x_ext;
  assign y_sum_next = r_y_sum + w_y_ext;
  assign count      = r_count;

  // Running sums and sample count; clear wins over enable
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_x_sum <= '0;
      r_y_sum <= '0;
      r_count <= '0;
    end else if (clear) begin
      r_x_sum <= '0;
      r_y_sum <= '0;
      r_count <= '0;
    end else if (en) begin
      r_x_sum <= x_sum_next;
      r_y_sum <= y_sum_next;
      r_count <= r_count + CW'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/uc_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uc_sweep_ctrl
// Description : Frequency-sweep sequencer. Steps the down-conversion phase
//               increment through a programmed list of points, discards a
//               settle window of decimated samples, integrates a dwell
//               window of I/Q and hands each sum out over valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module uc_sweep_ctrl
  import uc_ctrl_pkg::*;
#(
  parameter int PW = c_pw_default,
  parameter int DW = c_dw_default,
  parameter int CW = c_cw_default,
  parameter int AW = acc_width(DW, CW)
) (
  input  wire logic                 sys_clk,
  input  wire logic                 rst,
  input  wire logic                 start,
  input  wire logic                 abort,
  input  wire logic [PW-1:0]        cfg_start_inc,
  input  wire logic [PW-1:0]        cfg_step_inc,
  input  wire logic [CW-1:0]        cfg_n_points,
  input  wire logic [CW-1:0]        cfg_settle,
  input  wire logic [CW-1:0]        cfg_dwell,
  input  wire logic                 ce_down,
  input  wire logic signed [DW-1:0] sample_x,
  input  wire logic signed [DW-1:0] sample_y,
  output logic [PW-1:0]             phase_inc_down,
  output logic                      busy,
  output logic                      done,
  uc_sweep_ctrl_if.master           res
);

  sweep_state_t r_state;
  sweep_state_t w_state_nxt;

  // Configuration captured at start so CPU writes mid-sweep are harmless
  logic [PW-1:0] r_step;
  logic [CW-1:0] r_n_points;
  logic [CW-1:0] r_settle;
  logic [CW-1:0] r_dwell;

  logic [CW-1:0] r_index;
  logic [PW-1:0] r_phase_inc;
  logic [CW-1:0] r_settle_cnt;
  logic          r_busy;
  logic          r_done;

  logic                 r_res_valid;
  logic signed [AW-1:0] r_res_x;
  logic signed [AW-1:0] r_res_y;
  logic [CW-1:0]        r_res_index;

  logic                 w_load_cfg;
  logic                 w_acc_clear;
  logic                 w_acc_en;
  logic                 w_settle_inc;
  logic                 w_capture;
  logic                 w_xfer;
  logic                 w_advance;
  logic [CW-1:0]        w_dwell_eff;
  logic signed [AW-1:0] w_acc_x_next;
  logic signed [AW-1:0] w_acc_y_next;
  logic [CW-1:0]        w_acc_cnt;

  // A dwell of zero would never complete; integrate at least one sample
  assign w_dwell_eff = (r_dwell == '0) ? CW'(1) : r_dwell;

  uc_iq_accum #(
    .DW (DW),
    .CW (CW),
    .AW (AW)
  ) u_accum (
    .sys_clk    (sys_clk),
    .rst        (rst),
    .clear      (w_acc_clear),
    .en         (w_acc_en),
    .sample_x   (sample_x),
    .sample_y   (sample_y),
    .x_sum_next (w_acc_x_next),
    .y_sum_next (w_acc_y_next),
    .count      (w_acc_cnt)
  );

  // State register
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode and per-cycle datapath strobes; abort overrides everything
  always_comb begin
    w_state_nxt  = r_state;
    w_load_cfg   = 1'b0;
    w_acc_clear  = 1'b0;
    w_acc_en     = 1'b0;
    w_settle_inc = 1'b0;
    w_capture    = 1'b0;
    w_xfer       = 1'b0;
    w_advance    = 1'b0;
    if (abort) begin
      w_state_nxt = ST_IDLE;
      w_acc_clear = 1'b1;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            w_load_cfg  = 1'b1;
            w_acc_clear = 1'b1;
            w_state_nxt = (cfg_n_points == '0) ? ST_DONE : ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (r_settle == '0) begin
            w_state_nxt = ST_DWELL;
          end else if (ce_down) begin
            if (r_settle_cnt + CW'(1) == r_settle) w_state_nxt = ST_DWELL;
            else                                   w_settle_inc = 1'b1;
          end
        end
        ST_DWELL: begin
          if (ce_down) begin
            w_acc_en = 1'b1;
            if (w_acc_cnt + CW'(1) == w_dwell_eff) begin
              w_capture   = 1'b1;
              w_state_nxt = ST_STORE;
            end
          end
        end
        ST_STORE: begin
          // res_valid is high for the whole of STORE, so ready alone completes the transfer
          if (res.res_ready) begin
            w_xfer      = 1'b1;
            w_acc_clear = 1'b1;
            if (r_index == r_n_points - CW'(1)) begin
              w_state_nxt = ST_DONE;
            end else begin
              w_advance   = 1'b1;
              w_state_nxt = ST_SETTLE;
            end
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Configuration latch, point index and phase-increment stepping
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_step      <= '0;
      r_n_points  <= '0;
      r_settle    <= '0;
      r_dwell     <= '0;
      r_index     <= '0;
      r_phase_inc <= '0;
    end else if (w_load_cfg) begin
      r_step     <= cfg_step_inc;
      r_n_points <= cfg_n_points;
      r_settle   <= cfg_settle;
      r_dwell    <= cfg_dwell;
      r_index    <= '0;
      // An empty sweep leaves the receiver where it was
      if (cfg_n_points != '0) r_phase_inc <= cfg_start_inc;
    end else if (w_advance) begin
      r_index     <= r_index + CW'(1);
      r_phase_inc <= r_phase_inc + r_step;
    end
  end

  // Settle tick counter; restarts whenever SETTLE is not the current state
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst)                      r_settle_cnt <= '0;
    else if (w_settle_inc)        r_settle_cnt <= r_settle_cnt + CW'(1);
    else if (r_state != ST_SETTLE) r_settle_cnt <= '0;
  end

  // Result holding registers and valid flag
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_res_valid <= 1'b0;
      r_res_x     <= '0;
      r_res_y     <= '0;
      r_res_index <= '0;
    end else if (abort) begin
      r_res_valid <= 1'b0;
      r_res_x     <= '0;
      r_res_y     <= '0;
    end else if (w_capture) begin
      r_res_valid <= 1'b1;
      r_res_x     <= w_acc_x_next;
      r_res_y     <= w_acc_y_next;
      r_res_index <= r_index;
    end else if (w_xfer) begin
      r_res_valid <= 1'b0;
    end
  end

  // Registered status flags derived from the upcoming state
  always_ff @(posedge sys_clk or posedge rst) begin
    if (rst) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == ST_SETTLE) || (w_state_nxt == ST_DWELL) ||
                (w_state_nxt == ST_STORE);
      r_done <= (w_state_nxt == ST_DONE);
    end
  end

  assign phase_inc_down = r_phase_inc;
  assign busy           = r_busy;
  assign done           = r_done;
  assign res.res_valid  = r_res_valid;
  assign res.res_x_sum  = r_res_x;
  assign res.res_y_sum  = r_res_y;
  assign res.res_index  = r_res_index;

endmodule
`default_nettype wire

// File: tb/tb_uc_sweep_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uc_sweep_ctrl
// Description : Self-checking bench for the sweep sequencer: table of full
//               sweeps plus directed sequences for reset, alignment,
//               back-pressure, abort, empty sweep and accumulator range.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uc_sweep_ctrl;
  import uc_ctrl_pkg::*;

  localparam int PW = 19;
  localparam int DW = 16;
  localparam int CW = 16;
  localparam int AW = 32;

  logic                 sys_clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 abort;
  logic [PW-1:0]        cfg_start_inc;
  logic [PW-1:0]        cfg_step_inc;
  logic [CW-1:0]        cfg_n_points;
  logic [CW-1:0]        cfg_settle;
  logic [CW-1:0]        cfg_dwell;
  logic                 ce_down;
  logic signed [DW-1:0] sample_x;
  logic signed [DW-1:0] sample_y;
  logic [PW-1:0]        phase_inc_down;
  logic                 busy;
  logic                 done;

  int n_checks = 0;
  int n_errors = 0;

  uc_sweep_ctrl_if #(.AW(AW), .CW(CW)) res_if ();

  uc_sweep_ctrl #(.PW(PW), .DW(DW), .CW(CW), .AW(AW)) dut (
    .sys_clk        (sys_clk),
    .rst            (rst),
    .start          (start),
    .abort          (abort),
    .cfg_start_inc  (cfg_start_inc),
    .cfg_step_inc   (cfg_step_inc),
    .cfg_n_points   (cfg_n_points),
    .cfg_settle     (cfg_settle),
    .cfg_dwell      (cfg_dwell),
    .ce_down        (ce_down),
    .sample_x       (sample_x),
    .sample_y       (sample_y),
    .phase_inc_down (phase_inc_down),
    .busy           (busy),
    .done           (done),
    .res            (res_if.master)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct packed {
    logic [PW-1:0]          start_inc;
    logic [PW-1:0]          step_inc;
    logic [CW-1:0]          n_points;
    logic [CW-1:0]          settle;
    logic [CW-1:0]          dwell;
    logic signed [DW-1:0]   x;
    logic signed [DW-1:0]   y;
    logic signed [AW-1:0]   exp_x;
    logic signed [AW-1:0]   exp_y;
    logic [3:0][PW-1:0]     exp_ph;
  } vec_t;

  vec_t vecs [4];

  function automatic vec_t mk(input int si, input int st, input int n, input int se,
                              input int dw, input int x, input int y, input int ex,
                              input int ey, input int p0, input int p1, input int p2,
                              input int p3);
    vec_t v;
    v.start_inc = PW'(si);  v.step_inc = PW'(st);
    v.n_points  = CW'(n);   v.settle   = CW'(se);  v.dwell = CW'(dw);
    v.x         = DW'(x);   v.y        = DW'(y);
    v.exp_x     = AW'(ex);  v.exp_y    = AW'(ey);
    v.exp_ph[0] = PW'(p0);  v.exp_ph[1] = PW'(p1);
    v.exp_ph[2] = PW'(p2);  v.exp_ph[3] = PW'(p3);
    return v;
  endfunction

  // Drive point: 1 time unit after the rising edge; checks also happen here
  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic chk(input string name, input logic signed [63:0] act,
                     input logic signed [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_cfg(input int si, input int st, input int n, input int se,
                         input int dw, input int x, input int y);
    cfg_start_inc = PW'(si);
    cfg_step_inc  = PW'(st);
    cfg_n_points  = CW'(n);
    cfg_settle    = CW'(se);
    cfg_dwell     = CW'(dw);
    sample_x      = DW'(x);
    sample_y      = DW'(y);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Full sweep from a table entry with ready held high
  task automatic run_vec(input vec_t v, input int id);
    int got;
    int cyc;
    got = 0;
    cyc = 0;
    set_cfg(int'(v.start_inc), int'(v.step_inc), int'(v.n_points), int'(v.settle),
            int'(v.dwell), int'(v.x), int'(v.y));
    res_if.res_ready = 1'b1;
    pulse_start();
    chk($sformatf("v%0d phase_start", id), phase_inc_down, v.exp_ph[0]);
    chk($sformatf("v%0d busy", id), busy, 1);
    while (!done && cyc < 3000) begin
      ce_down = (cyc % 3 == 0);
      tick();
      cyc++;
      if (res_if.res_valid) begin
        chk($sformatf("v%0d p%0d x_sum", id, got), res_if.res_x_sum, v.exp_x);
        chk($sformatf("v%0d p%0d y_sum", id, got), res_if.res_y_sum, v.exp_y);
        chk($sformatf("v%0d p%0d index", id, got), res_if.res_index, got);
        if (got < 4)
          chk($sformatf("v%0d p%0d phase", id, got), phase_inc_down, v.exp_ph[got]);
        got++;
      end
    end
    ce_down = 1'b0;
    chk($sformatf("v%0d done", id), done, 1);
    chk($sformatf("v%0d n_results", id), got, v.n_points);
  endtask

  task automatic wait_valid(input string name, input int limit, input bit toggle);
    int cyc;
    cyc = 0;
    while (!res_if.res_valid && cyc < limit) begin
      if (toggle) ce_down = ~ce_down;
      tick();
      cyc++;
    end
    chk({name, " valid_timeout"}, res_if.res_valid, 1);
  endtask

  initial begin
    vecs[0] = mk(1000, 500, 3, 2, 4, 100, -50, 400, -200, 1000, 1500, 2000, 0);
    vecs[1] = mk(524188, 300, 2, 1, 0, 7, -3, 7, -3, 524188, 200, 0, 0);
    vecs[2] = mk(0, 1, 2, 0, 3, -1000, 2000, -3000, 6000, 0, 1, 0, 0);
    vecs[3] = mk(10, 524287, 4, 3, 2, 32767, -32768, 65534, -65536, 10, 9, 8, 7);

    rst = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    ce_down = 1'b0;
    res_if.res_ready = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0);
    tick();
    tick();
    chk("rst phase", phase_inc_down, 0);
    chk("rst valid", res_if.res_valid, 0);
    chk("rst x_sum", res_if.res_x_sum, 0);
    chk("rst y_sum", res_if.res_y_sum, 0);
    chk("rst index", res_if.res_index, 0);
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 4; i++) run_vec(vecs[i], i);

    // Asynchronous reset in the middle of a dwell window
    set_cfg(4000, 10, 2, 0, 50, 3, 3);
    pulse_start();
    ce_down = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    chk("mid busy", busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("arst phase", phase_inc_down, 0);
    chk("arst valid", res_if.res_valid, 0);
    chk("arst x_sum", res_if.res_x_sum, 0);
    chk("arst y_sum", res_if.res_y_sum, 0);
    chk("arst busy", busy, 0);
    chk("arst done", done, 0);
    tick();
    rst = 1'b0;
    tick();
    tick();
    chk("arst idle busy", busy, 0);
    chk("arst idle done", done, 0);
    ce_down = 1'b0;

    // Sample alignment: entry tick counts toward settle, last sample latency
    res_if.res_ready = 1'b0;
    set_cfg(777, 1, 1, 1, 2, 0, 0);
    pulse_start();
    ce_down = 1'b1; sample_x = 16'sd1;    sample_y = -16'sd1;    tick();
    ce_down = 1'b1; sample_x = 16'sd10;   sample_y = -16'sd10;   tick();
    ce_down = 1'b0; sample_x = 16'sd7777; sample_y = 16'sd7777;  tick();
    chk("align no early valid", res_if.res_valid, 0);
    ce_down = 1'b1; sample_x = 16'sd100;  sample_y = -16'sd100;  tick();
    chk("align valid", res_if.res_valid, 1);
    chk("align x_sum", res_if.res_x_sum, 110);
    chk("align y_sum", res_if.res_y_sum, -110);
    ce_down = 1'b1; sample_x = 16'sd1000; sample_y = 16'sd1000;  tick();
    chk("align store hold x", res_if.res_x_sum, 110);
    ce_down = 1'b0;
    res_if.res_ready = 1'b1;
    tick();
    chk("align done", done, 1);
    chk("align valid drop", res_if.res_valid, 0);
    chk("align busy", busy, 0);

    // Empty sweep goes straight to DONE, phase untouched
    set_cfg(12345, 1, 0, 1, 1, 0, 0);
    pulse_start();
    chk("n0 done", done, 1);
    chk("n0 busy", busy, 0);
    chk("n0 phase", phase_inc_down, 777);

    // Back-pressure on the result channel
    res_if.res_ready = 1'b0;
    set_cfg(50, 5, 2, 1, 3, 11, -22);
    pulse_start();
    wait_valid("bp p0", 200, 1'b1);
    chk("bp p0 x_sum", res_if.res_x_sum, 33);
    chk("bp p0 y_sum", res_if.res_y_sum, -66);
    chk("bp p0 index", res_if.res_index, 0);
    sample_x = 16'sd5000;
    for (int i = 0; i < 20; i++) begin
      ce_down = ~ce_down;
      tick();
      chk($sformatf("bp stall%0d valid", i), res_if.res_valid, 1);
      chk($sformatf("bp stall%0d x_sum", i), res_if.res_x_sum, 33);
    end
    chk("bp stall phase", phase_inc_down, 50);
    sample_x = 16'sd11;
    res_if.res_ready = 1'b1;
    tick();
    chk("bp release valid", res_if.res_valid, 0);
    chk("bp release phase", phase_inc_down, 55);
    wait_valid("bp p1", 200, 1'b1);
    chk("bp p1 x_sum", res_if.res_x_sum, 33);
    chk("bp p1 y_sum", res_if.res_y_sum, -66);
    chk("bp p1 index", res_if.res_index, 1);
    tick();
    chk("bp done", done, 1);
    ce_down = 1'b0;

    // Abort in SETTLE of point 1; start while busy must be ignored
    set_cfg(1000, 500, 3, 5, 1, 1, 1);
    res_if.res_ready = 1'b1;
    pulse_start();
    ce_down = 1'b1;
    cfg_start_inc = 19'd9999;
    cfg_n_points  = 16'd1;
    pulse_start();
    chk("busy start ignored phase", phase_inc_down, 1000);
    chk("busy start ignored busy", busy, 1);
    wait_valid("ab p0", 100, 1'b0);
    chk("ab p0 index", res_if.res_index, 0);
    tick();
    chk("ab p1 phase", phase_inc_down, 1500);
    chk("ab p1 busy", busy, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("ab busy", busy, 0);
    chk("ab done", done, 0);
    chk("ab valid", res_if.res_valid, 0);
    chk("ab phase hold", phase_inc_down, 1500);
    tick();
    chk("ab idle stays", busy, 0);
    cfg_start_inc = 19'd3000;
    pulse_start();
    chk("ab restart phase", phase_inc_down, 3000);
    wait_valid("ab restart", 100, 1'b0);
    chk("ab restart index", res_if.res_index, 0);
    chk("ab restart x_sum", res_if.res_x_sum, 1);
    tick();
    chk("ab restart done", done, 1);

    // Accumulator range: full-scale negative samples over the longest dwell
    res_if.res_ready = 1'b0;
    set_cfg(0, 0, 1, 0, 65535, -32768, 32767);
    ce_down = 1'b1;
    pulse_start();
    wait_valid("ovf", 70000, 1'b0);
    chk("ovf x_sum", res_if.res_x_sum, -64'sd2147450880);
    chk("ovf y_sum", res_if.res_y_sum, 64'sd2147385345);
    ce_down = 1'b0;
    res_if.res_ready = 1'b1;
    tick();
    chk("ovf done", done, 1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
